// File: rtl/neuron_mac_seq.sv
// Neuron dot-product sequencer: steers an external combinational ALU through MUL/ADD/ACT per pair.
// Optional build macro NEURON_BIAS_EN adds a `bias` port that seeds the accumulator per neuron.
module neuron_mac_seq #(
    parameter int unsigned nBits   = 32,
    parameter int unsigned nInputs = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [nBits-1:0] in_x,
    input  logic [nBits-1:0] in_w,
`ifdef NEURON_BIAS_EN
    input  logic [nBits-1:0] bias,
`endif
    input  logic [nBits-1:0] threshold,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [nBits-1:0] out_y,
    output logic [nBits-1:0] out_acc,
    output logic [2:0]       ALUControl,
    output logic [nBits-1:0] SrcA,
    output logic [nBits-1:0] SrcB,
    input  logic [nBits-1:0] ALUResult
);

    localparam int unsigned CntW = $clog2(nInputs) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(nInputs - 1);

    localparam logic [2:0] OpAdd  = 3'b000;
    localparam logic [2:0] OpMul  = 3'b001;
    localparam logic [2:0] OpAct  = 3'b010;
    localparam logic [2:0] OpPass = 3'b111;

    typedef enum logic [2:0] {
        StFetch,
        StMul,
        StAdd,
        StAct,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [nBits-1:0]  x_q, x_d;
    logic [nBits-1:0]  w_q, w_d;
    logic [nBits-1:0]  prod_q, prod_d;
    logic [nBits-1:0]  acc_q, acc_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [nBits-1:0]  out_y_q, out_y_d;
    logic [nBits-1:0]  out_acc_q, out_acc_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        w_d         = w_q;
        prod_d      = prod_q;
        acc_d       = acc_q;
        count_d     = count_q;
        out_y_d     = out_y_q;
        out_acc_d   = out_acc_q;
        ALUControl  = OpPass;
        SrcA        = acc_q;
        SrcB        = '0;

        unique case (state_q)
            StFetch: begin
                if (in_valid) begin
                    x_d     = in_x;
                    w_d     = in_w;
                    state_d = StMul;
`ifdef NEURON_BIAS_EN
                    if (count_q == '0) begin
                        acc_d = bias;
                    end
`endif
                end
            end
            StMul: begin
                ALUControl = OpMul;
                SrcA       = x_q;
                SrcB       = w_q;
                prod_d     = ALUResult;
                state_d    = StAdd;
            end
            StAdd: begin
                ALUControl = OpAdd;
                SrcA       = acc_q;
                SrcB       = prod_q;
                acc_d      = ALUResult;
                count_d    = count_q + CntW'(1);
                state_d    = (count_q == LastCnt) ? StAct : StFetch;
            end
            StAct: begin
                ALUControl = OpAct;
                SrcA       = acc_q;
                SrcB       = threshold;
                out_y_d    = ALUResult;
                out_acc_d  = acc_q;
                state_d    = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    acc_d   = '0;
                    count_d = '0;
                    state_d = StFetch;
                end
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        // Handshake flags are registered copies of the next state.
        in_ready_d  = (state_d == StFetch);
        out_valid_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StFetch;
            x_q         <= '0;
            w_q         <= '0;
            prod_q      <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            out_y_q     <= '0;
            out_acc_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            w_q         <= w_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            out_y_q     <= out_y_d;
            out_acc_q   <= out_acc_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_acc   = out_acc_q;

endmodule
